sdram_read_arbiter: RTL and testbench

- Shares one FPGA-to-HPS SDRAM Avalon-MM burst read port among NUM_REQ read masters, e.g. scanout, texture fetch and Z read.
- Arbitrates commands round-robin and forwards one burst command at a time.
- Tracks outstanding bursts in a small in-order FIFO so that returning readdatavalid beats reach the master that issued the burst.
- Sits between the rasterizer/scanout engines and one hps_0_f2h_sdramN_data read port of soc_system.

---
 rtl/sdram_arb_pkg.sv | 23 ++
 rtl/sdram_arb_tracker_fifo.sv | 77 +++++++
 rtl/sdram_read_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_read_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM read arbiter and its burst tracker.
package sdram_arb_pkg;

  localparam int NUM_REQ_DEF         = 3;
  localparam int ADDR_W_DEF          = 29;
  localparam int DATA_W_DEF          = 64;
  localparam int BURST_W_DEF         = 8;
  localparam int MAX_OUTSTANDING_DEF = 4;

  // Entry fields are sized for the widest supported build (8 masters, 16-bit bursts).
  localparam int ID_W  = 3;
  localparam int CNT_W = 16;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] count;
  } trk_entry_t;

endpackage

// File: rtl/sdram_arb_tracker_fifo.sv
// In-order FIFO of issued bursts; counts down the head burst's beats and pops on its last beat.
module sdram_arb_tracker_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTSTANDING_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  trk_entry_t      push_entry,
  input  logic            beat,
  output logic            full,
  output logic            empty,
  output logic            valid,
  output logic [ID_W-1:0] head_id
);

  localparam int PTR_W = $clog2(DEPTH);

  trk_entry_t         mem_reg [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic [CNT_W-1:0]   remaining_reg;
  logic [CNT_W-1:0]   remaining_next;
  logic [PTR_W-1:0]   rd_ptr_inc;
  logic               pop;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == (PTR_W+1)'(DEPTH));
  assign valid      = !empty;
  assign head_id    = mem_reg[rd_ptr_reg].id;
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);
  assign pop        = beat && !empty && (remaining_reg == CNT_W'(1));

  // The counter reloads whenever a new entry becomes head, including one pushed this cycle.
  always_comb begin
    remaining_next = remaining_reg;
    if (pop) begin
      if (count_reg > (PTR_W+1)'(1))
        remaining_next = mem_reg[rd_ptr_inc].count;
      else if (push)
        remaining_next = push_entry.count;
      else
        remaining_next = '0;
    end else if (empty && push) begin
      remaining_next = push_entry.count;
    end else if (beat && !empty) begin
      remaining_next = remaining_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_reg[wr_ptr_reg] <= push_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      remaining_reg <= '0;
    end else begin
      remaining_reg <= remaining_next;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_inc;
      if (push && !pop)
        count_reg <= count_reg + (PTR_W+1)'(1);
      else if (pop && !push)
        count_reg <= count_reg - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/sdram_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM burst read port among NUM_REQ masters,
// routing returned beats back in issue order.
module sdram_read_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ         = NUM_REQ_DEF,
  parameter int ADDR_W          = ADDR_W_DEF,
  parameter int DATA_W          = DATA_W_DEF,
  parameter int BURST_W         = BURST_W_DEF,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset_n,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*BURST_W-1:0] req_burstcount,
  input  logic [NUM_REQ-1:0]         req_read,
  output logic [NUM_REQ-1:0]         req_waitrequest,
  output logic [DATA_W-1:0]          req_readdata,
  output logic [NUM_REQ-1:0]         req_readdatavalid,
  output logic [ADDR_W-1:0]          sdram_address,
  output logic [BURST_W-1:0]         sdram_burstcount,
  output logic                       sdram_read,
  input  logic                       sdram_waitrequest,
  input  logic [DATA_W-1:0]          sdram_readdata,
  input  logic                       sdram_readdatavalid,
  output logic                       err
);

  localparam int GNT_W = $clog2(NUM_REQ);

  logic [1:0]         state_reg;
  logic [GNT_W-1:0]   grant_reg;
  logic [GNT_W-1:0]   rr_reg;
  logic               err_reg;
  logic [GNT_W-1:0]   winner;
  logic [GNT_W-1:0]   cidx;
  logic               found;
  int                 cand;
  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [BURST_W-1:0] burst_arr [NUM_REQ];
  logic               push;
  logic               trk_full;
  logic               trk_empty;
  logic               trk_valid;
  logic [ID_W-1:0]    head_id;
  trk_entry_t         push_entry;
  logic               ack_now;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_address[gi*ADDR_W +: ADDR_W];
    assign burst_arr[gi] = req_burstcount[gi*BURST_W +: BURST_W];
  end

  // Search starts one past the last grant so every master gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = rr_reg;
    cand   = 0;
    cidx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_reg) + k) % NUM_REQ;
      cidx = GNT_W'(cand);
      if (!found && req_read[cidx]) begin
        found  = 1'b1;
        winner = cidx;
      end
    end
  end

  assign push             = (state_reg == ISSUE) && !sdram_waitrequest;
  assign ack_now          = push || (state_reg == DROP);
  assign push_entry.id    = ID_W'(grant_reg);
  assign push_entry.count = CNT_W'(sdram_burstcount);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg        <= IDLE;
      grant_reg        <= '0;
      rr_reg           <= GNT_W'(NUM_REQ - 1);
      sdram_read       <= 1'b0;
      sdram_address    <= '0;
      sdram_burstcount <= '0;
      err_reg          <= 1'b0;
    end else begin
      if (sdram_readdatavalid && trk_empty)
        err_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (found && !trk_full) begin
            grant_reg <= winner;
            rr_reg    <= winner;
            // A zero-length burst is acknowledged and discarded, never issued.
            if (burst_arr[winner] == '0) begin
              state_reg <= DROP;
              err_reg   <= 1'b1;
            end else begin
              sdram_address    <= addr_arr[winner];
              sdram_burstcount <= burst_arr[winner];
              sdram_read       <= 1'b1;
              state_reg        <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!sdram_waitrequest) begin
            sdram_read <= 1'b0;
            state_reg  <= IDLE;
          end
        end
        DROP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  sdram_arb_tracker_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tracker (
    .clk        (clk_clk),
    .rst_n      (reset_reset_n),
    .push       (push),
    .push_entry (push_entry),
    .beat       (sdram_readdatavalid),
    .full       (trk_full),
    .empty      (trk_empty),
    .valid      (trk_valid),
    .head_id    (head_id)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_port
    assign req_waitrequest[gi]   = !(ack_now && (grant_reg == GNT_W'(gi)));
    assign req_readdatavalid[gi] = sdram_readdatavalid && trk_valid && (head_id == ID_W'(gi));
  end

  assign req_readdata = sdram_readdata;
  assign err          = err_reg;

endmodule

// File: tb/tb_sdram_read_arbiter.sv
// Randomized bench: masters and an SDRAM slave are modelled at transaction level and
// every port is compared against a round-robin / in-order-completion reference model.
module tb_sdram_read_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ADDR_W  = 29;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 8;
  localparam int MAX_OUT = 4;

  logic                       clk_clk = 1'b0;
  logic                       reset_reset_n = 1'b0;
  logic [NUM_REQ*ADDR_W-1:0]  req_address = '0;
  logic [NUM_REQ*BURST_W-1:0] req_burstcount = '0;
  logic [NUM_REQ-1:0]         req_read = '0;
  logic [NUM_REQ-1:0]         req_waitrequest;
  logic [DATA_W-1:0]          req_readdata;
  logic [NUM_REQ-1:0]         req_readdatavalid;
  logic [ADDR_W-1:0]          sdram_address;
  logic [BURST_W-1:0]         sdram_burstcount;
  logic                       sdram_read;
  logic                       sdram_waitrequest = 1'b1;
  logic [DATA_W-1:0]          sdram_readdata = '0;
  logic                       sdram_readdatavalid = 1'b0;
  logic                       err;

  always #5 clk_clk = ~clk_clk;

  sdram_read_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BURST_W(BURST_W), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk_clk             (clk_clk),
    .reset_reset_n       (reset_reset_n),
    .req_address         (req_address),
    .req_burstcount      (req_burstcount),
    .req_read            (req_read),
    .req_waitrequest     (req_waitrequest),
    .req_readdata        (req_readdata),
    .req_readdatavalid   (req_readdatavalid),
    .sdram_address       (sdram_address),
    .sdram_burstcount    (sdram_burstcount),
    .sdram_read          (sdram_read),
    .sdram_waitrequest   (sdram_waitrequest),
    .sdram_readdata      (sdram_readdata),
    .sdram_readdatavalid (sdram_readdatavalid),
    .err                 (err)
  );

  typedef struct { int id; int left; } ent_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_acks = 0;

  // Master and slave behaviour
  bit               m_req   [NUM_REQ];
  logic [ADDR_W-1:0] m_addr [NUM_REQ];
  int               m_burst [NUM_REQ];
  int               slave_q [$];
  logic [DATA_W-1:0] beat_data = '0;
  int req_pct = 60, wait_pct = 40, beat_pct = 50, spur_pct = 0;

  // Reference model: outstanding bursts in issue order, last grant, pending grant
  ent_t mq [$];
  int   last_id = NUM_REQ - 1;
  bit   granted = 1'b0;
  int   g_id = 0, g_burst = 0, g_age = 0;
  logic [ADDR_W-1:0] g_addr = '0;
  bit   exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    granted = 1'b0;
    last_id = NUM_REQ - 1;
    exp_err = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_sdram_read"},  64'(sdram_read), 64'(0));
    check({pfx, "_sdram_addr"},  64'(sdram_address), 64'(0));
    check({pfx, "_sdram_burst"}, 64'(sdram_burstcount), 64'(0));
    check({pfx, "_waitreq"},     64'(req_waitrequest), 64'({NUM_REQ{1'b1}}));
    check({pfx, "_dv"},          64'(req_readdatavalid), 64'(0));
    check({pfx, "_err"},         64'(err), 64'(0));
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!m_req[i] && $urandom_range(0, 99) < req_pct) begin
        m_req[i]   = 1'b1;
        m_addr[i]  = ADDR_W'($urandom);
        m_burst[i] = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4));
      end
      req_read[i] = m_req[i];
      req_address[i*ADDR_W +: ADDR_W]     = m_addr[i];
      req_burstcount[i*BURST_W +: BURST_W] = BURST_W'(m_burst[i]);
    end
    sdram_waitrequest   = ($urandom_range(0, 99) < wait_pct);
    sdram_readdatavalid = 1'b0;
    if (reset_reset_n) begin
      if (slave_q.size() > 0 && $urandom_range(0, 99) < beat_pct) begin
        sdram_readdatavalid = 1'b1;
        slave_q[0] = slave_q[0] - 1;
        if (slave_q[0] == 0) slave_q.delete(0);
      end else if (slave_q.size() == 0 && $urandom_range(0, 99) < spur_pct) begin
        sdram_readdatavalid = 1'b1;
      end
      beat_data      = {$urandom, $urandom};
      sdram_readdata = beat_data;
    end
  endtask

  task automatic observe();
    logic [NUM_REQ-1:0] exp_wr;
    logic [NUM_REQ-1:0] exp_dv;
    bit exp_rd, ack, was_granted, got_one;
    int occ0, c;
    if (!reset_reset_n) begin
      check_reset_outputs("rst");
      return;
    end
    occ0        = mq.size();
    was_granted = granted;
    check("err", 64'(err), 64'(exp_err));

    exp_wr = {NUM_REQ{1'b1}};
    ack    = 1'b0;
    if (granted && g_age >= 1 &&
        ((g_burst == 0 && g_age == 1) || (g_burst != 0 && !sdram_waitrequest))) begin
      exp_wr = ~(NUM_REQ'(1) << g_id);
      ack    = 1'b1;
    end
    check("waitrequest", 64'(req_waitrequest), 64'(exp_wr));

    exp_rd = granted && g_burst != 0 && g_age >= 1;
    check("sdram_read", 64'(sdram_read), 64'(exp_rd));
    if (exp_rd) begin
      check("sdram_address", 64'(sdram_address), 64'(g_addr));
      check("sdram_burstcount", 64'(sdram_burstcount), 64'(g_burst));
    end

    exp_dv = '0;
    if (sdram_readdatavalid) begin
      if (mq.size() == 0) begin
        exp_err = 1'b1;
      end else begin
        exp_dv = NUM_REQ'(1) << mq[0].id;
        check("readdata", req_readdata, beat_data);
        mq[0].left = mq[0].left - 1;
        if (mq[0].left == 0) mq.delete(0);
      end
    end
    check("readdatavalid", 64'(req_readdatavalid), 64'(exp_dv));

    if (sdram_read && !sdram_waitrequest && sdram_burstcount != '0)
      slave_q.push_back(int'(sdram_burstcount));

    if (ack) begin
      if (g_burst != 0) mq.push_back('{g_id, g_burst});
      m_req[g_id] = 1'b0;
      granted = 1'b0;
      n_acks++;
    end

    if (!was_granted && occ0 < MAX_OUT) begin
      got_one = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        c = (last_id + k) % NUM_REQ;
        if (!got_one && m_req[c]) begin
          got_one = 1'b1;
          granted = 1'b1;
          g_id    = c;
          g_burst = m_burst[c];
          g_addr  = m_addr[c];
          g_age   = 0;
          last_id = c;
          if (g_burst == 0) exp_err = 1'b1;
        end
      end
    end

    if (granted) begin
      g_age++;
      if (g_age > 200) begin
        check("ack_timeout", 64'(g_age), 64'(0));
        granted = 1'b0;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_clk);
      #1 drive();
      @(negedge clk_clk);
      observe();
    end
  endtask

  task automatic reset_mid_op();
    int tries;
    bit hit;
    req_pct = 90; wait_pct = 70; beat_pct = 20; spur_pct = 0;
    tries = 0;
    hit   = 1'b0;
    while (!hit && tries < 2000) begin
      @(posedge clk_clk);
      #1 drive();
      if (granted && g_burst != 0 && g_age >= 1 && mq.size() >= 2) begin
        hit = 1'b1;
        #2 reset_reset_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        model_reset();
      end
      @(negedge clk_clk);
      observe();
      tries++;
    end
    if (!hit) begin
      reset_reset_n = 1'b0;
      model_reset();
    end
    run_cycles(2);
    @(posedge clk_clk);
    #1 drive();
    #1 reset_reset_n = 1'b1;
    @(negedge clk_clk);
    observe();
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      m_req[i] = 1'b0; m_addr[i] = '0; m_burst[i] = 0;
    end
    model_reset();
    run_cycles(3);
    @(posedge clk_clk);
    #1 drive();
    #1 reset_reset_n = 1'b1;
    @(negedge clk_clk);
    observe();

    req_pct = 60; wait_pct = 40; beat_pct = 50; spur_pct = 0;
    run_cycles(1500);

    // Starve the read data so the tracker fills, then let it drain.
    req_pct = 90; wait_pct = 20; beat_pct = 0;
    run_cycles(200);
    beat_pct = 80;
    run_cycles(300);

    req_pct = 10; wait_pct = 30; beat_pct = 60; spur_pct = 10;
    run_cycles(500);

    for (int r = 0; r < 3; r++) begin
      reset_mid_op();
      req_pct = 60; wait_pct = 40; beat_pct = 50; spur_pct = 5;
      run_cycles(300);
    end

    req_pct = 0; wait_pct = 0; beat_pct = 100; spur_pct = 0;
    run_cycles(100);
    check("outstanding_drained", 64'(mq.size()), 64'(0));
    if (n_acks < 50) check("ack_activity", 64'(n_acks), 64'(50));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
